// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding,
// default byte width and the owner-to-grant mapping.
package uart_tx_arb_pkg;

  localparam int DBIT_DEF = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] owner_grant(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_arb_counter.sv
// Modulo-M counter with synchronous clear; max_tick_o flags the terminal count.
module uart_tx_arb_counter #(
  parameter int M = 1024,
  parameter int N = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic max_tick_o
);

  localparam logic [N-1:0] LAST = N'(M - 1);

  logic [N-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_arb.sv
// Two-client message-locking arbiter in front of the UART transmit FIFO.
// A client owns the UART until its last byte or until it goes idle too long.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int TO_CYC = 1024,
  parameter int TO_BIT = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic            req1_valid,
  input  logic [DBIT-1:0] req0_data,
  input  logic [DBIT-1:0] req1_data,
  input  logic            req0_last,
  input  logic            req1_last,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [1:0]      grant,
  output logic            timeout_tick,
  output arb_state_e      dbg_state
);

  // Handshake: a byte moves when the owner's valid and ready are both high in
  // the same cycle; ready depends only on lock state and tx_full, never on valid.

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;

  logic            locked;
  logic            own_valid;
  logic            own_last;
  logic [DBIT-1:0] own_data;
  logic            xfer;
  logic            idle_en;
  logic            cnt_max;
  logic            expire;

  assign locked    = (state_q == ST_LOCKED);
  assign own_valid = owner_q ? req1_valid : req0_valid;
  assign own_last  = owner_q ? req1_last  : req0_last;
  assign own_data  = owner_q ? req1_data  : req0_data;
  assign xfer      = locked & own_valid & ~tx_full;
  // Backpressured cycles still have valid high, so they clear the idle count.
  assign idle_en   = locked & ~own_valid;
  assign expire    = idle_en & cnt_max;

  uart_tx_arb_counter #(
    .M (TO_CYC),
    .N (TO_BIT)
  ) u_idle_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (~idle_en),
    .en_i       (idle_en),
    .max_tick_o (cnt_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid | req1_valid) begin
          state_d = ST_LOCKED;
          owner_d = (req0_valid & req1_valid) ? rr_q : req1_valid;
        end
      end
      ST_LOCKED: begin
        if ((xfer & own_last) | expire) begin
          state_d = ST_IDLE;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant        = 2'b00;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    wr_uart      = 1'b0;
    w_data       = '0;
    timeout_tick = 1'b0;
    if (locked) begin
      grant        = owner_grant(owner_q);
      req0_ready   = ~owner_q & ~tx_full;
      req1_ready   = owner_q & ~tx_full;
      wr_uart      = xfer;
      timeout_tick = expire;
      if (xfer) begin
        w_data = own_data;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_uart_tx_arb;
  import uart_tx_arb_pkg::*;

  localparam int DBIT   = 8;
  localparam int TO_CYC = 8;
  localparam int TO_BIT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0_valid, req1_valid;
  logic [DBIT-1:0] req0_data, req1_data;
  logic            req0_last, req1_last;
  logic            req0_ready, req1_ready;
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic [1:0]      grant;
  logic            timeout_tick;
  arb_state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit m_locked;
  int m_owner;
  int m_rr;
  int m_idle_run;
  bit m_xfer;
  int m_xfer_owner;
  logic [DBIT-1:0] exp_q[$];
  int obs_wr    = 0;
  int obs_ticks = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .DBIT   (DBIT),
    .TO_CYC (TO_CYC),
    .TO_BIT (TO_BIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_data    (req0_data),
    .req1_data    (req1_data),
    .req0_last    (req0_last),
    .req1_last    (req1_last),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .tx_full      (tx_full),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .grant        (grant),
    .timeout_tick (timeout_tick),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_owner    = 0;
    m_rr       = 0;
    m_idle_run = 0;
    m_xfer     = 1'b0;
    exp_q.delete();
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit              own_v, own_l, e_tick;
    logic [DBIT-1:0] own_d;
    logic [1:0]      e_grant;
    @(negedge clk);
    own_v   = (m_owner == 1) ? req1_valid : req0_valid;
    own_l   = (m_owner == 1) ? req1_last  : req0_last;
    own_d   = (m_owner == 1) ? req1_data  : req0_data;
    e_grant = !m_locked ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    m_xfer       = m_locked && own_v && !tx_full;
    m_xfer_owner = m_owner;
    e_tick  = m_locked && !own_v && (m_idle_run + 1 == TO_CYC);
    if (m_xfer) exp_q.push_back(own_d);
    check("grant", grant, e_grant);
    check("ready0", req0_ready, m_locked && m_owner == 0 && !tx_full);
    check("ready1", req1_ready, m_locked && m_owner == 1 && !tx_full);
    check("wr_uart", wr_uart, m_xfer);
    check("w_data", w_data, m_xfer ? own_d : '0);
    check("timeout_tick", timeout_tick, e_tick);
    check("dbg_state", dbg_state == ST_LOCKED, m_locked);
    if (wr_uart) begin
      obs_wr++;
      if (exp_q.size() == 0) check("sb_unexpected_wr", wr_uart, 1'b0);
      else                   check("sb_data", w_data, exp_q.pop_front());
    end
    if (timeout_tick) obs_ticks++;
    @(posedge clk);
    if (!m_locked) begin
      if (req0_valid || req1_valid) begin
        m_locked = 1'b1;
        m_owner  = (req0_valid && req1_valid) ? m_rr : (req1_valid ? 1 : 0);
      end
      m_idle_run = 0;
    end else if ((m_xfer && own_l) || e_tick) begin
      m_locked   = 1'b0;
      m_rr       = 1 - m_owner;
      m_idle_run = 0;
    end else begin
      m_idle_run = own_v ? 0 : m_idle_run + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_wr_uart", wr_uart, 1'b0);
    check("rst_w_data", w_data, '0);
    check("rst_timeout", timeout_tick, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Offer one byte from client c until the model accepts it; cyc = cycles taken.
  task automatic send_byte(input int c, input logic [DBIT-1:0] d, input bit last, output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    if (c == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = last; end
    else        begin req1_valid = 1'b1; req1_data = d; req1_last = last; end
    for (int i = 0; i < 40; i++) begin
      cycle();
      cyc++;
      if (m_xfer && m_xfer_owner == c) begin ok = 1'b1; break; end
    end
    check("accept_in_time", ok, 1'b1);
    if (c == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  initial begin
    int cyc, wr0, tk0;
    int rem[2];
    int stall[2];
    logic [DBIT-1:0] cur[2];

    reset = 1'b1; tx_full = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    req0_last = 1'b0; req1_last = 1'b0;
    #1;
    do_reset();

    // single client, three-byte message
    wr0 = obs_wr;
    send_byte(0, 8'h41, 1'b0, cyc);
    check("grant_latency", cyc, 2);
    send_byte(0, 8'h42, 1'b0, cyc);
    check("back_to_back_42", cyc, 1);
    send_byte(0, 8'h43, 1'b1, cyc);
    check("back_to_back_43", cyc, 1);
    check("msg_wr_count", obs_wr - wr0, 3);
    check("idle_after_last", grant, 2'b00);
    cycle();

    // both clients request right after reset: client 0 first
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h55; req1_last = 1'b1;
    send_byte(0, 8'h10, 1'b0, cyc);
    check("c0_first", cyc, 2);
    send_byte(0, 8'h11, 1'b1, cyc);
    send_byte(1, 8'h55, 1'b1, cyc);
    check("c1_after_c0", cyc, 2);

    // backpressure mid-message
    tk0 = obs_ticks;
    wr0 = obs_wr;
    send_byte(0, 8'h21, 1'b0, cyc);
    tx_full = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h22; req0_last = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    tx_full = 1'b0;
    send_byte(0, 8'h22, 1'b0, cyc);
    check("resume_after_full", cyc, 1);
    send_byte(0, 8'h23, 1'b1, cyc);
    check("full_no_timeout", obs_ticks - tk0, 0);
    check("full_wr_count", obs_wr - wr0, 3);

    // owner goes quiet: forced release hands over to waiting client 1
    tk0 = obs_ticks;
    send_byte(0, 8'h31, 1'b0, cyc);
    send_byte(1, 8'h66, 1'b1, cyc);
    check("timeout_handover", cyc, TO_CYC + 2);
    check("timeout_pulses", obs_ticks - tk0, 1);

    // reset during a locked message
    req0_valid = 1'b1; req0_data = 8'h77; req0_last = 1'b0;
    cycle();
    check("pre_reset_wr", wr_uart, 1'b1);
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h79; req1_last = 1'b1;
    send_byte(0, 8'h78, 1'b1, cyc);
    check("rr_restart_c0", cyc, 2);
    send_byte(1, 8'h79, 1'b1, cyc);
    check("rr_then_c1", cyc, 2);

    // random traffic
    for (int c = 0; c < 2; c++) begin
      rem[c]   = $urandom_range(1, 4);
      stall[c] = 0;
      cur[c]   = 8'($urandom);
    end
    for (int n = 0; n < 600; n++) begin
      bit v[2];
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int c = 0; c < 2; c++) begin
        if (stall[c] > 0) begin
          v[c] = 1'b0;
          stall[c]--;
        end else if ($urandom_range(0, 39) == 0) begin
          v[c] = 1'b0;
          stall[c] = $urandom_range(3, 12);
        end else begin
          v[c] = ($urandom_range(0, 3) != 0);
        end
      end
      req0_valid = v[0]; req0_data = cur[0]; req0_last = (rem[0] == 1);
      req1_valid = v[1]; req1_data = cur[1]; req1_last = (rem[1] == 1);
      tx_full = ($urandom_range(0, 3) == 0);
      cycle();
      if (m_xfer) begin
        rem[m_xfer_owner]--;
        cur[m_xfer_owner] = 8'($urandom);
        if (rem[m_xfer_owner] == 0) rem[m_xfer_owner] = $urandom_range(1, 4);
      end
    end
    check("sb_leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
